// File: rtl/led_seq_controller.sv
// Eight-LED pattern sequencer: STATIC, BLINK, FILL and CHASE patterns stepped every STEP_DIV clocks.
// Define LED_SEQ_ONESHOT_EN to run each pattern once and pulse done; otherwise patterns loop.
module led_seq_controller #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned STEP_DIV = CLK_FREQ / 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_data,
  input  logic       stop,
  output logic [7:0] leds,
  output logic       busy,
  output logic       step_tick,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_STATIC = 2'd0;
  localparam logic [1:0]  MODE_BLINK  = 2'd1;
  localparam logic [1:0]  MODE_FILL   = 2'd2;
  localparam logic [1:0]  MODE_CHASE  = 2'd3;
  localparam logic [31:0] STEP_LAST   = 32'(STEP_DIV - 32'd1);

  state_t      state_r, state_s;
  logic [1:0]  mode_r, mode_s;
  logic [7:0]  data_r, data_s;
  logic [7:0]  leds_r, leds_s;
  logic [31:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic        fill_up_r, fill_up_s;
  logic        tick_r, tick_s;
  logic        accept_s;
`ifdef LED_SEQ_ONESHOT_EN
  logic [3:0]  steps_r, steps_s;
  logic        done_r, done_s;
`endif

  // One pattern step applied to the current LED value.
  function automatic logic [7:0] step_leds(input logic [1:0] mode, input logic [7:0] cur,
                                           input logic [7:0] data, input logic [2:0] idx,
                                           input logic up);
    logic [7:0] res;
    res = cur;
    case (mode)
      MODE_STATIC: res = cur;
      MODE_BLINK:  res = (cur == data) ? 8'h00 : data;
      MODE_FILL:   res[idx] = up;
      MODE_CHASE:  res = {cur[6:0], cur[7]};
      default:     res = cur;
    endcase
    return res;
  endfunction

`ifdef LED_SEQ_ONESHOT_EN
  // Index of the final step of one pass through each pattern.
  function automatic logic [3:0] last_step(input logic [1:0] mode);
    logic [3:0] res;
    case (mode)
      MODE_BLINK: res = 4'd1;
      MODE_FILL:  res = 4'd15;
      MODE_CHASE: res = 4'd7;
      default:    res = 4'd0;
    endcase
    return res;
  endfunction
`endif

  assign cmd_ready = (state_r != ST_LOAD) && !stop;
  assign accept_s  = cmd_valid && cmd_ready;
  assign leds      = leds_r;
  assign busy      = (state_r != ST_IDLE);
  assign step_tick = tick_r;
`ifdef LED_SEQ_ONESHOT_EN
  assign done      = done_r;
`else
  assign done      = 1'b0;
`endif

  // Next-state, pattern stepping and command handling; stop outranks a new command.
  always_comb begin
    state_s   = state_r;
    mode_s    = mode_r;
    data_s    = data_r;
    leds_s    = leds_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    fill_up_s = fill_up_r;
    tick_s    = 1'b0;
`ifdef LED_SEQ_ONESHOT_EN
    steps_s   = steps_r;
    done_s    = 1'b0;
`endif
    if (stop) begin
      state_s = ST_IDLE;
      leds_s  = 8'h00;
    end else if (accept_s) begin
      state_s   = ST_LOAD;
      mode_s    = cmd_mode;
      data_s    = cmd_data;
      leds_s    = (cmd_mode == MODE_FILL) ? 8'h00 : cmd_data;
      cnt_s     = 32'd0;
      idx_s     = 3'd0;
      fill_up_s = 1'b1;
`ifdef LED_SEQ_ONESHOT_EN
      steps_s   = 4'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_LOAD: begin
          cnt_s = 32'd0;
`ifdef LED_SEQ_ONESHOT_EN
          if (mode_r == MODE_STATIC) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
`else
          state_s = ST_RUN;
`endif
        end
        ST_RUN: begin
          if (cnt_r == STEP_LAST) begin
            cnt_s  = 32'd0;
            tick_s = 1'b1;
            leds_s = step_leds(mode_r, leds_r, data_r, idx_r, fill_up_r);
            // FILL walks index 0..7 rising, then 0..7 falling.
            if (mode_r == MODE_FILL) begin
              idx_s     = idx_r + 3'd1;
              fill_up_s = (idx_r == 3'd7) ? !fill_up_r : fill_up_r;
            end else begin
              idx_s     = idx_r;
            end
`ifdef LED_SEQ_ONESHOT_EN
            if (steps_r == last_step(mode_r)) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
              steps_s = 4'd0;
            end else begin
              steps_s = steps_r + 4'd1;
            end
`endif
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mode_r    <= 2'd0;
      data_r    <= 8'h00;
      leds_r    <= 8'h00;
      cnt_r     <= 32'd0;
      idx_r     <= 3'd0;
      fill_up_r <= 1'b1;
      tick_r    <= 1'b0;
`ifdef LED_SEQ_ONESHOT_EN
      steps_r   <= 4'd0;
      done_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      data_r    <= data_s;
      leds_r    <= leds_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      fill_up_r <= fill_up_s;
      tick_r    <= tick_s;
`ifdef LED_SEQ_ONESHOT_EN
      steps_r   <= steps_s;
      done_r    <= done_s;
`endif
    end
  end

endmodule

// File: tb/tb_led_seq_controller.sv
// Scoreboard bench for led_seq_controller with STEP_DIV=4: stimulus queues expected step/done
// events, a negedge monitor pops and compares them. Honours LED_SEQ_ONESHOT_EN.
module tb_led_seq_controller;
  localparam int unsigned STEP = 4;
`ifdef LED_SEQ_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [7:0]  leds;
    logic        tick;
    logic        done;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       stop = 1'b0;
  logic       cmd_ready, busy, step_tick, done;
  logic [7:0] leds;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [7:0] fill_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] chase81_tab [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
  logic [7:0] chase01_tab [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  led_seq_controller #(.STEP_DIV(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_data(cmd_data), .stop(stop), .leds(leds),
    .busy(busy), .step_tick(step_tick), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every step_tick/done the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && (step_tick || done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d tick=%0b done=%0b leds=%02h, expected no event",
                 cyc, step_tick, done, leds);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_cycle", cyc, mon_e.cyc);
        check("ev_leds", {24'd0, leds}, {24'd0, mon_e.leds});
        check("ev_tick", {31'd0, step_tick}, {31'd0, mon_e.tick});
        check("ev_done", {31'd0, done}, {31'd0, mon_e.done});
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic [7:0] d, output int unsigned a);
    cmd_mode  = m;
    cmd_data  = d;
    cmd_valid = 1'b1;
    next();
    a = cyc;
    cmd_valid = 1'b0;
  endtask

  // Expected k-th step (k from 1) of a command whose LOAD cycle is a.
  task automatic push_step(input int unsigned a, input int k, input logic [7:0] v, input bit last);
    ev_t e;
    e.cyc  = a + 1 + STEP * k;
    e.leds = v;
    e.tick = 1'b1;
    e.done = ONESHOT && last;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected events never seen, required 0 outstanding", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_stop(input string nm);
    stop = 1'b1;
    #1;
    check({nm, "_ready_low"}, {31'd0, cmd_ready}, 32'd0);
    next();
    stop = 1'b0;
    #1;
    check({nm, "_leds"}, {24'd0, leds}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int unsigned a, b;
    ev_t e;
    int ticks;

    // Reset then idle.
    repeat (2) next();
    rst_n = 1'b1;
    #1;
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      next();
      if (step_tick) ticks++;
    end
    check("idle_ticks", ticks, 32'd0);
    check("idle_leds", {24'd0, leds}, 32'd0);

    // FILL: one full up/down pass.
    issue(2'd2, 8'hC3, a);
    check("fill_load_leds", {24'd0, leds}, 32'd0);
    check("fill_load_ready", {31'd0, cmd_ready}, 32'd0);
    check("fill_load_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 16; k++) push_step(a, k, fill_tab[k-1], k == 16);
    drain("fill_drain", 120);
    do_stop("fill_stop");

    // CHASE 81, then stop and command together.
    issue(2'd3, 8'h81, a);
    check("chase_load_leds", {24'd0, leds}, 32'h81);
    for (int k = 1; k <= 8; k++) push_step(a, k, chase81_tab[k-1], k == 8);
    drain("chase_drain", 80);
    stop = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 2'd0;
    cmd_data = 8'h77;
    #1;
    check("sc_ready", {31'd0, cmd_ready}, 32'd0);
    next();
    stop = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("sc_leds", {24'd0, leds}, 32'd0);
    check("sc_busy", {31'd0, busy}, 32'd0);
    check("sc_ready_after", {31'd0, cmd_ready}, 32'd1);
    repeat (10) next();
    check("sc_leds_held", {24'd0, leds}, 32'd0);

    // Preempt BLINK AA with FILL on a would-be step cycle.
    issue(2'd1, 8'hAA, a);
    check("blink_load_leds", {24'd0, leds}, 32'hAA);
    push_step(a, 1, 8'h00, 1'b0);
    push_step(a, 2, 8'hAA, 1'b1);
    drain("blink_drain", 40);
    while (cyc < a + 12) next();
    check("pre_ready", {31'd0, cmd_ready}, 32'd1);
    issue(2'd2, 8'h00, b);
    check("pre_load_leds", {24'd0, leds}, 32'd0);
    check("pre_load_ready", {31'd0, cmd_ready}, 32'd0);
    check("pre_load_busy", {31'd0, busy}, 32'd1);
    push_step(b, 1, 8'h01, 1'b0);
    push_step(b, 2, 8'h03, 1'b0);
    next();
    check("pre_ready_run", {31'd0, cmd_ready}, 32'd1);
    drain("pre_drain", 40);
    do_stop("pre_stop");

    // STATIC 5A.
    issue(2'd0, 8'h5A, a);
`ifdef LED_SEQ_ONESHOT_EN
    e.cyc = a + 1;
    e.leds = 8'h5A;
    e.tick = 1'b0;
    e.done = 1'b1;
    exp_q.push_back(e);
`else
    push_step(a, 1, 8'h5A, 1'b0);
    push_step(a, 2, 8'h5A, 1'b0);
`endif
    drain("static_drain", 40);
    check("static_leds", {24'd0, leds}, 32'h5A);
    do_stop("static_stop");

    // CHASE 01: one-shot completion, or looping with done held low.
    issue(2'd3, 8'h01, a);
    for (int k = 1; k <= 8; k++) push_step(a, k, chase01_tab[k-1], k == 8);
    drain("c01_drain", 80);
    check("c01_leds", {24'd0, leds}, 32'h01);
`ifdef LED_SEQ_ONESHOT_EN
    check("c01_busy", {31'd0, busy}, 32'd0);
    next();
    check("c01_done_once", {31'd0, done}, 32'd0);
`else
    check("c01_busy", {31'd0, busy}, 32'd1);
    check("c01_done_low", {31'd0, done}, 32'd0);
`endif
    do_stop("c01_stop");

    // Reset mid-pattern beats stop and cmd_valid.
    issue(2'd3, 8'h11, a);
    next();
    rst_n = 1'b0;
    stop = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 2'd1;
    cmd_data = 8'hFF;
    repeat (2) next();
    rst_n = 1'b1;
    stop = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("mrst_leds", {24'd0, leds}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (20) next();
    check("mrst_leds_held", {24'd0, leds}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule

// File: doc/led_seq_controller.md
LED_SEQ_CONTROLLER -- requirements
Module: led_seq_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning system clock frequency in Hz (informational).
REQ-002 SHALL have parameter STEP_DIV, default CLK_FREQ/4, meaning clk cycles per pattern step; legal range 2..2^32-1.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command can be accepted this cycle.
REQ-007 SHALL have port cmd_mode, input, 2, mode: 0 STATIC, 1 BLINK, 2 FILL, 3 CHASE.
REQ-008 SHALL have port cmd_data, input, 8, pattern operand.
REQ-009 SHALL have port stop, input, 1, abort the current pattern.
REQ-010 SHALL have port leds, output, 8, registered LED drive.
REQ-011 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-012 SHALL have port step_tick, output, 1, one-cycle pulse on each step boundary.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse (see REQ-030).

Function
REQ-014 SHALL implement states IDLE, LOAD and RUN.
REQ-015 SHALL accept a command on any cycle with cmd_valid=1 and cmd_ready=1, latching cmd_mode and cmd_data and entering LOAD on the next edge.
REQ-016 SHALL drive cmd_ready=1 in IDLE and RUN, 0 in LOAD, and 0 in any cycle with stop=1 (combinational).
REQ-017 SHALL, in LOAD, set leds to the initial value (cmd_data for STATIC, BLINK and CHASE; 8'h00 for FILL), clear the step counter and FILL index, and go to RUN after exactly one cycle.
REQ-018 SHALL, in RUN, count the step counter 0..STEP_DIV-1 and wrap to 0; at count STEP_DIV-1 it SHALL pulse step_tick and apply one step to leds on the same edge.
REQ-019 SHALL leave leds unchanged on STATIC steps.
REQ-020 SHALL toggle leds between the latched cmd_data and 8'h00 on BLINK steps.
REQ-021 SHALL, on FILL steps, set leds[index] in the ascending phase for index 0..7 and clear leds[index] in the descending phase for index 0..7: 16 steps per cycle, then repeat.
REQ-022 SHALL rotate leds left by one position on CHASE steps (bit 7 to bit 0).
REQ-023 SHALL, when a command is accepted in RUN, abandon the current pattern and re-enter LOAD with the new command; there is no step_tick in that cycle.
REQ-024 SHALL, with stop=1 in any state, go to IDLE and clear leds to 8'h00 on the next edge; stop takes priority over cmd_valid in the same cycle, and that command is not accepted.
REQ-025 SHALL hold the counter and leds in IDLE and never pulse step_tick there.

Reset
REQ-026 SHALL, on rst_n=0 at a clk edge, set state IDLE, leds=8'h00, counter=0, index=0, ascending phase, latched command=0, step_tick=0 and done=0.
REQ-027 SHALL give reset priority over stop and cmd_valid, and SHALL discard any pattern in progress when reset occurs mid-operation.
REQ-028 SHALL drive cmd_ready=1 and busy=0 in the first cycle after reset is released.

Configuration
REQ-029 SHALL use macro LED_SEQ_ONESHOT_EN to select one-shot operation.
REQ-030 SHALL, with LED_SEQ_ONESHOT_EN defined, finish each pattern once and then pulse done for one cycle, go to IDLE and keep leds at their last value:
- STATIC: done on the cycle after LOAD.
- BLINK: after 2 steps.
- CHASE: after 8 steps.
- FILL: after 16 steps.
REQ-031 SHALL, with LED_SEQ_ONESHOT_EN undefined, loop all patterns until stop or a new command, and tie done to constant 0.

Verification
REQ-032 SHALL cover reset then idle: rst_n low 2 cycles -> leds=00, busy=0, cmd_ready=1, no step_tick for 100 cycles.
REQ-033 SHALL cover FILL with STEP_DIV=4: command mode 2 -> leds 01,03,07,...,FF then FE,FC,...,00, each value changing every 4 cycles with step_tick.
REQ-034 SHALL cover CHASE with STEP_DIV=4: command mode 3, data 81 -> leds 81,03,06,0C,... with an update every 4 cycles.
REQ-035 SHALL cover preempt: BLINK AA running, FILL accepted mid-step -> LOAD gives leds=00, cmd_ready=0 for one cycle, counter restarts from 0.
REQ-036 SHALL cover stop versus command: stop=1 and cmd_valid=1 in the same cycle during RUN -> cmd_ready=0, command not accepted, leds=00 and busy=0 on the next cycle.
REQ-037 SHALL cover one-shot (LED_SEQ_ONESHOT_EN defined): CHASE 01 -> done pulses once after 8 steps, leds=01, busy=0; with the macro undefined, done stays 0.
